// File: rtl/video_timing_pkg.sv
// ============================================================================
// Module      : video_timing_pkg
// Description : Shared types and helpers for the raster timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_timing_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } axis_state_t;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_axis_counter.sv
// ============================================================================
// Module      : video_axis_counter
// Description : One raster axis: region FSM plus position counter with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CW     = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] next_cnt,
    output axis_state_t   state,
    output axis_state_t   next_state,
    output logic          wrap
);

    localparam int c_total   = total(ACTIVE, FP, SYNC, BP);
    localparam int c_b_front = ACTIVE;
    localparam int c_b_sync  = ACTIVE + FP;
    localparam int c_b_back  = ACTIVE + FP + SYNC;
    localparam logic [CW-1:0] c_last = CW'(c_total - 1);

    if (ACTIVE < 1 || c_total > (1 << CW)) begin : g_param_check
        $fatal(1, "video_axis_counter: ACTIVE must be >= 1 and total must fit in CW bits");
    end

    logic [CW-1:0] r_cnt;
    axis_state_t   r_state;
    logic [CW-1:0] w_next_cnt;
    axis_state_t   w_next_state;
    logic [CW:0]   w_next_ext;
    logic          w_wrap;

    assign w_wrap     = adv && (r_cnt == c_last);
    assign w_next_ext = {1'b0, w_next_cnt};

    always_comb begin
        w_next_cnt = r_cnt;
        if (adv) begin
            w_next_cnt = w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    // Empty porch/sync regions are jumped over on the boundary edge itself.
    always_comb begin
        w_next_state = r_state;
        if (w_wrap) begin
            w_next_state = ST_ACTIVE;
        end else if (adv) begin
            case (r_state)
                ST_ACTIVE: begin
                    if (w_next_ext == (CW+1)'(c_b_front)) begin
                        if (FP != 0)
                            w_next_state = ST_FRONT;
                        else if (SYNC != 0)
                            w_next_state = ST_SYNC;
                        else
                            w_next_state = ST_BACK;
                    end
                end
                ST_FRONT: begin
                    if (w_next_ext == (CW+1)'(c_b_sync))
                        w_next_state = (SYNC != 0) ? ST_SYNC : ST_BACK;
                end
                ST_SYNC: begin
                    if (w_next_ext == (CW+1)'(c_b_back))
                        w_next_state = ST_BACK;
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_state <= ST_ACTIVE;
        end else begin
            r_cnt   <= w_next_cnt;
            r_state <= w_next_state;
        end
    end

    assign cnt        = r_cnt;
    assign next_cnt   = w_next_cnt;
    assign state      = r_state;
    assign next_state = w_next_state;
    assign wrap       = w_wrap;

endmodule

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module      : video_timing_gen
// Description : Raster timing source producing hs/vs, blanks, de and coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CW       = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    output logic          hs,
    output logic          vs,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          line_odd,
    output logic          frame_start
);

    logic [CW-1:0] w_h_cnt, w_h_next_cnt, w_v_cnt, w_v_next_cnt;
    axis_state_t   w_h_state, w_h_next_state, w_v_state, w_v_next_state;
    logic          w_h_wrap, w_v_wrap, w_v_adv;

    assign w_v_adv = ce_pix & w_h_wrap;

    video_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_axis (
        .clk        (clk),
        .reset      (reset),
        .adv        (ce_pix),
        .cnt        (w_h_cnt),
        .next_cnt   (w_h_next_cnt),
        .state      (w_h_state),
        .next_state (w_h_next_state),
        .wrap       (w_h_wrap)
    );

    video_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_axis (
        .clk        (clk),
        .reset      (reset),
        .adv        (w_v_adv),
        .cnt        (w_v_cnt),
        .next_cnt   (w_v_next_cnt),
        .state      (w_v_state),
        .next_state (w_v_next_state),
        .wrap       (w_v_wrap)
    );

    // Current-state and vertical wrap are not needed for output decode.
    logic w_unused;
    assign w_unused = ^{w_h_state, w_v_state, w_v_wrap};

    logic r_hs, r_vs, r_hblank, r_vblank, r_de, r_line_odd, r_frame_start;

    // Decoding next-state values keeps the registered outputs aligned with hcnt/vcnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_de          <= 1'b0;
            r_line_odd    <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (ce_pix) begin
            r_hs          <= (w_h_next_state == ST_SYNC) ? HS_POL : ~HS_POL;
            r_vs          <= (w_v_next_state == ST_SYNC) ? VS_POL : ~VS_POL;
            r_hblank      <= (w_h_next_state != ST_ACTIVE);
            r_vblank      <= (w_v_next_state != ST_ACTIVE);
            r_de          <= (w_h_next_state == ST_ACTIVE) && (w_v_next_state == ST_ACTIVE);
            r_line_odd    <= w_v_next_cnt[0];
            r_frame_start <= (w_h_next_cnt == '0) && (w_v_next_cnt == '0);
        end
    end

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign de          = r_de;
    assign hcnt        = w_h_cnt;
    assign vcnt        = w_v_cnt;
    assign line_odd    = r_line_odd;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Self-checking bench: three builds against a raster model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce_pix = 1'b0;

    always #5 clk = ~clk;

    logic hs0, vs0, hb0, vb0, de0, lo0, fs0;
    logic hs1, vs1, hb1, vb1, de1, lo1, fs1;
    logic hs2, vs2, hb2, vb2, de2, lo2, fs2;
    logic [CW-1:0] hc0, vc0, hc1, vc1, hc2, vc2;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) u_dut0 (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .hs(hs0), .vs(vs0), .hblank(hb0), .vblank(vb0), .de(de0),
        .hcnt(hc0), .vcnt(vc0), .line_odd(lo0), .frame_start(fs0)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(0), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(0),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) u_dut1 (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .hs(hs1), .vs(vs1), .hblank(hb1), .vblank(vb1), .de(de1),
        .hcnt(hc1), .vcnt(vc1), .line_odd(lo1), .frame_start(fs1)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) u_dut2 (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .hs(hs2), .vs(vs2), .hblank(hb2), .vblank(vb2), .de(de2),
        .hcnt(hc2), .vcnt(vc2), .line_odd(lo2), .frame_start(fs2)
    );

    typedef struct {
        int ha, hf, hy, hb;
        int va, vf, vy, vb;
        bit hp, vp;
    } cfg_t;

    cfg_t cfg [3];
    int   mh [3];
    int   mv [3];
    bit   mforced [3];
    bit   mfs [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
        end
    endtask

    // Raster position model: the coordinate pair is the whole state; outputs follow from region ranges.
    task automatic model_step(input bit r, input bit c);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                mh[k] = 0;
                mv[k] = 0;
                mforced[k] = 1'b1;
                mfs[k] = 1'b0;
            end else if (c) begin
                mh[k]++;
                if (mh[k] == cfg[k].ha + cfg[k].hf + cfg[k].hy + cfg[k].hb) begin
                    mh[k] = 0;
                    mv[k]++;
                    if (mv[k] == cfg[k].va + cfg[k].vf + cfg[k].vy + cfg[k].vb)
                        mv[k] = 0;
                end
                mforced[k] = 1'b0;
                mfs[k] = (mh[k] == 0) && (mv[k] == 0);
            end
        end
    endtask

    task automatic check_inst(input int k, input logic hs_, input logic vs_, input logic hb_,
                              input logic vb_, input logic de_, input logic lo_, input logic fs_,
                              input logic [CW-1:0] hc_, input logic [CW-1:0] vc_);
        int hsy0, vsy0;
        bit e_hs, e_vs, e_hb, e_vb;
        hsy0 = cfg[k].ha + cfg[k].hf;
        vsy0 = cfg[k].va + cfg[k].vf;
        if (mforced[k]) begin
            e_hs = ~cfg[k].hp;
            e_vs = ~cfg[k].vp;
            e_hb = 1'b1;
            e_vb = 1'b1;
        end else begin
            e_hs = (mh[k] >= hsy0 && mh[k] < hsy0 + cfg[k].hy) ? cfg[k].hp : ~cfg[k].hp;
            e_vs = (mv[k] >= vsy0 && mv[k] < vsy0 + cfg[k].vy) ? cfg[k].vp : ~cfg[k].vp;
            e_hb = (mh[k] >= cfg[k].ha);
            e_vb = (mv[k] >= cfg[k].va);
        end
        chk("hcnt", k, 32'(hc_), mh[k]);
        chk("vcnt", k, 32'(vc_), mv[k]);
        chk("hs", k, 32'(hs_), int'(e_hs));
        chk("vs", k, 32'(vs_), int'(e_vs));
        chk("hblank", k, 32'(hb_), int'(e_hb));
        chk("vblank", k, 32'(vb_), int'(e_vb));
        chk("de", k, 32'(de_), int'(!e_hb && !e_vb));
        chk("line_odd", k, 32'(lo_), mv[k] % 2);
        chk("frame_start", k, 32'(fs_), int'(mfs[k]));
    endtask

    task automatic cycle(input bit r, input bit c);
        reset  = r;
        ce_pix = c;
        @(posedge clk);
        model_step(r, c);
        #1;
        cyc++;
        check_inst(0, hs0, vs0, hb0, vb0, de0, lo0, fs0, hc0, vc0);
        check_inst(1, hs1, vs1, hb1, vb1, de1, lo1, fs1, hc1, vc1);
        check_inst(2, hs2, vs2, hb2, vb2, de2, lo2, fs2, hc2, vc2);
    endtask

    initial begin
        int fs_count;
        int n;

        cfg[0] = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1};
        cfg[1] = '{8, 0, 3, 2, 4, 1, 2, 0, 1'b1, 1'b1};
        cfg[2] = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0};

        // Reset state, including reset with ce_pix high
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        chk("rst_hcnt", 0, 32'(hc0), 0);
        chk("rst_vcnt", 0, 32'(vc0), 0);
        chk("rst_hs", 0, 32'(hs0), 0);
        chk("rst_vs", 0, 32'(vs0), 0);
        chk("rst_hblank", 0, 32'(hb0), 1);
        chk("rst_vblank", 0, 32'(vb0), 1);
        chk("rst_de", 0, 32'(de0), 0);
        chk("rst_fs", 0, 32'(fs0), 0);
        chk("rst_hs_neg", 2, 32'(hs2), 1);

        // Idle after reset: blanking holds until the first ce
        cycle(1'b0, 1'b0);
        chk("idle_de", 0, 32'(de0), 0);

        // One full frame with ce_pix held high
        fs_count = 0;
        for (int i = 1; i <= 120; i++) begin
            cycle(1'b0, 1'b1);
            if (fs0 === 1'b1) fs_count++;
            if (i == 1) begin
                chk("first_hcnt", 0, 32'(hc0), 1);
                chk("first_de", 0, 32'(de0), 1);
            end
            if (i == 8) begin
                chk("h8_hblank", 0, 32'(hb0), 1);
                chk("h8_de", 0, 32'(de0), 0);
            end
            if (i == 10) chk("h10_hs", 0, 32'(hs0), 1);
            if (i == 13) chk("h13_hs", 0, 32'(hs0), 0);
            if (i == 15) begin
                chk("wrap_hcnt", 0, 32'(hc0), 0);
                chk("wrap_vcnt", 0, 32'(vc0), 1);
                chk("wrap_odd", 0, 32'(lo0), 1);
            end
            if (i == 60) chk("v4_vblank", 0, 32'(vb0), 1);
            if (i == 75) chk("v5_vs", 0, 32'(vs0), 1);
            if (i == 120) begin
                chk("frame_fs", 0, 32'(fs0), 1);
                chk("frame_hcnt", 0, 32'(hc0), 0);
                chk("frame_vcnt", 0, 32'(vc0), 0);
            end
        end
        chk("fs_pulses", 0, 32'(fs_count), 1);

        // ce_pix once every three clocks; frame_start must hold through the gaps
        cycle(1'b0, 1'b0);
        chk("fs_hold", 0, 32'(fs0), 1);
        for (int i = 0; i < 45; i++)
            cycle(1'b0, (i % 3) == 0);

        // Walk to hcnt=11, vcnt=5 and reset in the middle of both syncs
        n = 0;
        while (!(mh[0] == 11 && mv[0] == 5) && n < 200) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        chk("seek_reached", 0, 32'(mh[0] == 11 && mv[0] == 5), 1);
        chk("mid_hs", 0, 32'(hs0), 1);
        chk("mid_vs", 0, 32'(vs0), 1);
        cycle(1'b1, 1'b0);
        chk("mid_rst_hs", 0, 32'(hs0), 0);
        chk("mid_rst_vs", 0, 32'(vs0), 0);
        chk("mid_rst_hcnt", 0, 32'(hc0), 0);
        chk("mid_rst_vcnt", 0, 32'(vc0), 0);
        chk("mid_rst_de", 0, 32'(de0), 0);
        chk("mid_rst_hblank", 0, 32'(hb0), 1);
        cycle(1'b0, 1'b1);
        chk("post_rst_hcnt", 0, 32'(hc0), 1);
        chk("post_rst_de", 0, 32'(de0), 1);

        // Two-plus frames for the zero-porch and inverted-polarity builds
        for (int i = 0; i < 250; i++) begin
            cycle(1'b0, 1'b1);
            if (hc1 == 4'd8) chk("zp_hs_at8", 1, 32'(hs1), 1);
            if (hc2 >= 4'd10 && hc2 <= 4'd12) chk("neg_hs_sync", 2, 32'(hs2), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
